// File: rtl/latex_stream_checker.sv
// latex_stream_checker
// Captures the function-side (lhs) and transform-side (rhs) LaTeX character
// streams. Each zero-terminated string is framed per side, and the checker
// reports its length and Fletcher-16 checksum. The first DEPTH characters of
// each string are kept in a per-side buffer so they can be read back.
module latex_stream_checker #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    lhs,
    input  logic [7:0]    rhs,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [7:0]    lhs_len,
    output logic [7:0]    rhs_len,
    output logic [15:0]   lhs_sum,
    output logic [15:0]   rhs_sum,
    output logic [1:0]    overflow,
    input  logic          rd_side,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    // Top-level capture FSM encoding
    localparam logic [1:0] TOP_IDLE  = 2'd0;
    localparam logic [1:0] TOP_ARMED = 2'd1;
    localparam logic [1:0] TOP_DONE  = 2'd2;

    // Per-side framing FSM encoding
    localparam logic [1:0] SIDE_WAIT_TERM  = 2'd0;
    localparam logic [1:0] SIDE_WAIT_START = 2'd1;
    localparam logic [1:0] SIDE_RECV       = 2'd2;
    localparam logic [1:0] SIDE_FIN        = 2'd3;

    // Widened DEPTH so that len values up to 255 compare correctly even at DEPTH=256
    localparam logic [8:0] DEPTH_W   = 9'(DEPTH);
    localparam logic [9:0] TIMER_MAX = 10'd1023;

    logic [1:0]       top_state_reg;
    logic [9:0]       timer_reg;
    logic             timeout_reg;
    logic             armed;
    logic [1:0]       fin;
    logic             rd_side_reg;
    logic [1:0][7:0]  side_bytes;

    assign armed      = (top_state_reg == TOP_ARMED);
    assign side_bytes = {rhs, lhs};

    // Top FSM: arm on start, finish when both sides framed a string or the timer expires
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_state_reg <= TOP_IDLE;
            timer_reg     <= '0;
            timeout_reg   <= 1'b0;
        end else if (start) begin
            // start re-arms from any state and overrides a same-cycle completion
            top_state_reg <= TOP_ARMED;
            timer_reg     <= '0;
            timeout_reg   <= 1'b0;
        end else begin
            case (top_state_reg)
                TOP_IDLE: begin
                    top_state_reg <= TOP_IDLE;
                end
                TOP_ARMED: begin
                    timer_reg <= timer_reg + 10'd1;
                    if (&fin) begin
                        top_state_reg <= TOP_DONE;
                    end else if (timer_reg == TIMER_MAX) begin
                        top_state_reg <= TOP_DONE;
                        timeout_reg   <= 1'b1;
                    end
                end
                TOP_DONE: begin
                    top_state_reg <= TOP_IDLE;
                end
                default: begin
                    top_state_reg <= TOP_IDLE;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_side
            logic [1:0] state_reg;
            logic [7:0] len_reg;
            logic [7:0] sum1_reg;
            logic [7:0] sum2_reg;
            logic       ovf_reg;
            logic [7:0] rd_reg;
            logic [7:0] mem [DEPTH];

            logic [7:0] in_byte;
            logic       count_en;
            logic       fits;
            logic [8:0] sum1_wide;
            logic [8:0] sum2_wide;
            logic [7:0] sum1_next;
            logic [7:0] sum2_next;
            logic [7:0] len_next;

            assign in_byte = side_bytes[gi];

            // Counting decision and exact mod-255 Fletcher update for the current byte
            always_comb begin
                count_en  = armed && !start && (in_byte != 8'h00) &&
                            ((state_reg == SIDE_WAIT_START) || (state_reg == SIDE_RECV));
                fits      = ({1'b0, len_reg} < DEPTH_W);
                len_next  = (len_reg == 8'hFF) ? 8'hFF : (len_reg + 8'd1);
                sum1_wide = {1'b0, sum1_reg} + {1'b0, in_byte};
                // Subtracting 255 in 8 bits is exact because the true result is below 255
                sum1_next = (sum1_wide >= 9'd255) ? (sum1_wide[7:0] - 8'd255) : sum1_wide[7:0];
                sum2_wide = {1'b0, sum2_reg} + {1'b0, sum1_next};
                sum2_next = (sum2_wide >= 9'd255) ? (sum2_wide[7:0] - 8'd255) : sum2_wide[7:0];
            end

            // Framing FSM plus length, checksum and overflow accumulation
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_reg <= SIDE_WAIT_TERM;
                    len_reg   <= '0;
                    sum1_reg  <= '0;
                    sum2_reg  <= '0;
                    ovf_reg   <= 1'b0;
                end else if (start) begin
                    state_reg <= SIDE_WAIT_TERM;
                    len_reg   <= '0;
                    sum1_reg  <= '0;
                    sum2_reg  <= '0;
                    ovf_reg   <= 1'b0;
                end else if (armed) begin
                    case (state_reg)
                        SIDE_WAIT_TERM: begin
                            // Align to a string boundary; any partial string is dropped
                            if (in_byte == 8'h00) begin
                                state_reg <= SIDE_WAIT_START;
                            end
                        end
                        SIDE_WAIT_START: begin
                            if (in_byte != 8'h00) begin
                                state_reg <= SIDE_RECV;
                            end
                        end
                        SIDE_RECV: begin
                            if (in_byte == 8'h00) begin
                                state_reg <= SIDE_FIN;
                            end
                        end
                        default: begin
                            state_reg <= SIDE_FIN;
                        end
                    endcase
                    if (count_en) begin
                        len_reg  <= len_next;
                        sum1_reg <= sum1_next;
                        sum2_reg <= sum2_next;
                        if (!fits) begin
                            ovf_reg <= 1'b1;
                        end
                    end
                end
            end

            // Capture buffer: store counted bytes at their string index, registered readback
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mem[i] <= 8'h00;
                    end
                    rd_reg <= 8'h00;
                end else begin
                    if (count_en && fits) begin
                        mem[len_reg[AW-1:0]] <= in_byte;
                    end
                    rd_reg <= mem[rd_addr];
                end
            end
        end
    endgenerate

    assign fin = {(g_side[1].state_reg == SIDE_FIN), (g_side[0].state_reg == SIDE_FIN)};

    // Remember which side was addressed so the output mux matches the registered byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_side_reg <= 1'b0;
        end else begin
            rd_side_reg <= rd_side;
        end
    end

    assign rd_data  = rd_side_reg ? g_side[1].rd_reg : g_side[0].rd_reg;
    assign busy     = (top_state_reg == TOP_ARMED);
    assign done     = (top_state_reg == TOP_DONE);
    assign timeout  = timeout_reg;
    assign lhs_len  = g_side[0].len_reg;
    assign rhs_len  = g_side[1].len_reg;
    assign lhs_sum  = {g_side[0].sum2_reg, g_side[0].sum1_reg};
    assign rhs_sum  = {g_side[1].sum2_reg, g_side[1].sum1_reg};
    assign overflow = {g_side[1].ovf_reg, g_side[0].ovf_reg};

endmodule

// File: tb/tb_latex_stream_checker.sv
// Bench for latex_stream_checker: stream stimulus is built as per-side byte
// arrays, a string-level reference model predicts each capture result, and a
// monitor compares results at every done pulse and every readback.
module tb_latex_stream_checker;

    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int NS    = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    lhs;
    logic [7:0]    rhs;
    logic          start;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [7:0]    lhs_len;
    logic [7:0]    rhs_len;
    logic [15:0]   lhs_sum;
    logic [15:0]   rhs_sum;
    logic [1:0]    overflow;
    logic          rd_side;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;

    latex_stream_checker #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .lhs(lhs), .rhs(rhs), .start(start),
        .busy(busy), .done(done), .timeout(timeout),
        .lhs_len(lhs_len), .rhs_len(rhs_len),
        .lhs_sum(lhs_sum), .rhs_sum(rhs_sum), .overflow(overflow),
        .rd_side(rd_side), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int busy_run = 0;

    logic [7:0] strm [2][NS];
    logic [7:0] mem_model [2][DEPTH];

    typedef struct {
        int l_len;
        int l_sum;
        int r_len;
        int r_sum;
        int ovf;
        int timed_out;
        int dcyc;
    } exp_t;
    exp_t expq[$];

    typedef struct {
        int data;
        int due;
    } rd_t;
    rd_t rdq[$];

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        tests++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, expv);
        end
    endfunction

    // String-level model: skip to first 0x00, skip zeros, then the string runs to the next 0x00.
    // Only the first 'limit' samples are seen. Optionally records the stored characters.
    function automatic void side_model(input int side, input int limit, input bit wr,
                                       output int fin_k, output int len, output int sum, output int ovf);
        int i;
        int cnt;
        int s1;
        int s2;
        i = 0; cnt = 0; s1 = 0; s2 = 0;
        fin_k = 1 << 20;
        while (i < limit && strm[side][i] != 8'h00) i++;
        i++;
        while (i < limit && strm[side][i] == 8'h00) i++;
        while (i < limit && strm[side][i] != 8'h00) begin
            s1 = (s1 + int'(strm[side][i])) % 255;
            s2 = (s2 + s1) % 255;
            if (wr && cnt < DEPTH) mem_model[side][cnt] = strm[side][i];
            cnt++;
            i++;
        end
        if (i < limit) fin_k = i + 1;
        len = (cnt > 255) ? 255 : cnt;
        sum = s2 * 256 + s1;
        ovf = (cnt > DEPTH) ? 1 : 0;
    endfunction

    function automatic void clear_strm();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < NS; i++) strm[s][i] = 8'h00;
    endfunction

    function automatic void gen_random();
        int p;
        int n;
        clear_strm();
        for (int s = 0; s < 2; s++) begin
            p = 0;
            n = $urandom_range(0, 4);
            for (int i = 0; i < n; i++) begin strm[s][p] = 8'($urandom_range(1, 255)); p++; end
            p += $urandom_range(1, 3);
            n = $urandom_range(1, 45);
            for (int i = 0; i < n; i++) begin strm[s][p] = 8'($urandom_range(1, 255)); p++; end
        end
    endfunction

    function automatic void fill_basic();
        clear_strm();
        strm[0][1] = 8'h61; strm[0][2] = 8'h62;
        strm[1][1] = 8'h73;
    endfunction

    // mode 0: run to done (expected result queued); 1: re-armed early; 2: re-armed on the completion edge.
    // Modes 1 and 2 must be followed directly by another capture.
    task automatic capture(input int mode, input int abort_n);
        int kl, kr, ll, lr, sl, sr, ol, orv, kmax, d, cycles;
        exp_t e;
        side_model(0, NS, 1'b0, kl, ll, sl, ol);
        side_model(1, NS, 1'b0, kr, lr, sr, orv);
        kmax = (kl > kr) ? kl : kr;
        d = (kmax + 1 <= 1024) ? kmax + 1 : 1024;
        if (mode == 0) cycles = d;
        else if (mode == 1) cycles = (abort_n < d - 1) ? abort_n : d - 1;
        else cycles = d - 1;
        if (mode == 0) begin
            e.l_len = ll; e.l_sum = sl; e.r_len = lr; e.r_sum = sr;
            e.ovf = ol | (orv << 1);
            e.timed_out = (kmax + 1 > 1024) ? 1 : 0;
            e.dcyc = d;
            expq.push_back(e);
        end
        side_model(0, cycles, 1'b1, kl, ll, sl, ol);
        side_model(1, cycles, 1'b1, kr, lr, sr, orv);
        @(posedge clk); #1;
        start = 1'b1; lhs = 8'h00; rhs = 8'h00;
        for (int i = 1; i <= cycles; i++) begin
            @(posedge clk); #1;
            if (i == 1) busy_run = 0;
            start = 1'b0;
            lhs = strm[0][i-1];
            rhs = strm[1][i-1];
        end
    endtask

    task automatic rd_check(input int side, input int addr);
        rd_t r;
        @(posedge clk); #1;
        rd_side = side[0];
        rd_addr = addr[AW-1:0];
        r.data = int'(mem_model[side][addr]);
        r.due = cyc + 1;
        rdq.push_back(r);
    endtask

    task automatic check_reset_outputs();
        chk("rst_ctl", 32'({busy, done, timeout, overflow}), 32'd0);
        chk("rst_len", 32'({lhs_len, rhs_len}), 32'd0);
        chk("rst_sum", {lhs_sum, rhs_sum}, 32'd0);
        chk("rst_rd", 32'(rd_data), 32'd0);
    endtask

    // Monitor: compare capture results on each done pulse and readback bytes when due
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy) busy_run++;
            if (done) begin
                if (expq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_done: got done=1 expected done=0 at cycle %0d", cyc);
                end else begin
                    e = expq.pop_front();
                    chk("lhs_len", 32'(lhs_len), 32'(e.l_len));
                    chk("lhs_sum", 32'(lhs_sum), 32'(e.l_sum));
                    chk("rhs_len", 32'(rhs_len), 32'(e.r_len));
                    chk("rhs_sum", 32'(rhs_sum), 32'(e.r_sum));
                    chk("overflow", 32'(overflow), 32'(e.ovf));
                    chk("timeout", 32'(timeout), 32'(e.timed_out));
                    chk("busy_cycles", 32'(busy_run), 32'(e.dcyc));
                    chk("busy_at_done", 32'(busy), 32'd0);
                    $display("[TB] capture done: lhs len=%0d sum=%04h rhs len=%0d sum=%04h ovf=%0b to=%0b busy_cycles=%0d",
                             lhs_len, lhs_sum, rhs_len, rhs_sum, overflow, timeout, busy_run);
                end
            end
            while (rdq.size() > 0 && rdq[0].due <= cyc) begin
                chk("rd_data", 32'(rd_data), 32'(rdq[0].data));
                $display("[TB] readback side=%0d addr=%0d data=%02h", rd_side, rd_addr, rd_data);
                void'(rdq.pop_front());
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < DEPTH; i++) mem_model[s][i] = 8'h00;
        rst = 1'b1; start = 1'b0; lhs = 8'h00; rhs = 8'h00; rd_side = 1'b0; rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Basic capture: "ab" and "s"
        fill_basic();
        capture(0, 0);
        rd_check(0, 1);
        rd_check(0, 2);
        rd_check(0, 0);
        rd_check(1, 0);

        // Start lands mid-string: "xy" is discarded, "q" is captured
        clear_strm();
        strm[0][0] = 8'h78; strm[0][1] = 8'h79; strm[0][3] = 8'h71;
        strm[1][1] = 8'h73;
        capture(0, 0);

        // Overflow: 40 x 0xFF on lhs
        clear_strm();
        for (int i = 1; i <= 40; i++) strm[0][i] = 8'hFF;
        strm[1][1] = 8'h73;
        capture(0, 0);
        rd_check(0, 31);
        rd_check(0, 0);

        // Timeout: rhs never shows a terminator
        fill_basic();
        for (int i = 0; i < NS; i++) strm[1][i] = 8'h41;
        capture(0, 0);
        rd_check(1, 0);

        // start on the completion edge suppresses done
        fill_basic();
        capture(2, 0);
        gen_random();
        capture(0, 0);

        // Randomized captures, some re-armed early or on the completion edge
        for (int it = 0; it < 12; it++) begin
            int m;
            gen_random();
            m = $urandom_range(0, 2);
            if (m != 0) begin
                capture(m, $urandom_range(2, 20));
                gen_random();
            end
            capture(0, 0);
            for (int k = 0; k < 3; k++) rd_check($urandom_range(0, 1), $urandom_range(0, DEPTH - 1));
        end

        // Reset during an armed capture
        gen_random();
        strm[0][0] = 8'h00; strm[1][0] = 8'h00;
        for (int i = 1; i <= 30; i++) begin strm[0][i] = 8'h55; strm[1][i] = 8'h66; end
        capture(1, 6);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < DEPTH; i++) mem_model[s][i] = 8'h00;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; lhs = 8'h00; rhs = 8'h00;
        repeat (20) @(posedge clk);
        #1;
        chk("busy_after_rst", 32'(busy), 32'd0);
        rd_check(0, 1);
        rd_check(1, 0);

        // One more normal capture after reset
        fill_basic();
        capture(0, 0);
        @(posedge clk); #1;
        lhs = 8'h00; rhs = 8'h00;

        // Drain the scoreboard within a bounded time
        for (int w = 0; w < 2000; w++) begin
            if (expq.size() == 0 && rdq.size() == 0) break;
            @(posedge clk);
        end
        repeat (3) @(posedge clk);
        chk("scoreboard_drain", 32'(expq.size() + rdq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
